// File: rtl/div32x32.sv
// div32x32: sequential radix-2^BITS_PER_CYCLE restoring 32/32 unsigned divider with start/busy handshake.
// Define DIV32_DBZ_FLAG_EN to add the div_by_zero output.
module div32x32 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder
`ifdef DIV32_DBZ_FLAG_EN
    ,
    output logic        div_by_zero
`endif
);
    localparam int N = 32 / BITS_PER_CYCLE;

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
        $error("div32x32: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] dvd, dvs, qacc, nd, nq;
    logic [32:0] rem, nr;
    logic [4:0]  cnt;

    // The 33-bit partial remainder keeps the compare exact; b=0 naturally yields all-ones/a.
    always_comb begin
        nr = rem;
        nd = dvd;
        nq = qacc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            nr = {nr[31:0], nd[31]};
            nd = nd << 1;
            nq = {nq[30:0], nr >= {1'b0, dvs}};
            nr = nq[0] ? nr - {1'b0, dvs} : nr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            qacc      <= '0;
`ifdef DIV32_DBZ_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                state     <= RUN;
                busy      <= 1'b1;
                quotient  <= '0;
                remainder <= '0;
                cnt       <= '0;
                dvd       <= a;
                dvs       <= b;
                rem       <= '0;
                qacc      <= '0;
`ifdef DIV32_DBZ_FLAG_EN
                div_by_zero <= (b == 32'd0);
`endif
            end
        end else begin
            dvd  <= nd;
            rem  <= nr;
            qacc <= nq;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'(N - 1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                quotient  <= nq;
                remainder <= nr[31:0];
                cnt       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_div32x32.sv
// tb_div32x32: checks div32x32 for BITS_PER_CYCLE 1, 2 and 4 against an arithmetic reference model.
module tb_div32x32;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       start = '0;
    logic [31:0]      a = '0;
    logic [31:0]      b = '0;
    logic [2:0]       busy_v;
    logic [2:0][31:0] q_v, r_v;
`ifdef DIV32_DBZ_FLAG_EN
    logic [2:0]       dbz_v;
`endif
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div32x32 #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk),
            .reset(reset),
            .start(start[g]),
            .a(a),
            .b(b),
            .busy(busy_v[g]),
            .quotient(q_v[g]),
            .remainder(r_v[g])
`ifdef DIV32_DBZ_FLAG_EN
            ,
            .div_by_zero(dbz_v[g])
`endif
        );
    end

    function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) ? x : x % y;
    endfunction

    task automatic launch(input int i, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        while (busy_v[i] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input int i, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eq, input logic [31:0] er, input string tag);
        int cyc;
        launch(i, x, y);
        compared++;
        if (busy_v[i] !== 1'b1 || q_v[i] !== 32'd0 || r_v[i] !== 32'd0) begin
            mismatched++;
            $display("FAIL %s bpc=%0d accept: busy=%b q=%h r=%h, expected busy=1 q=0 r=0",
                     tag, 1 << i, busy_v[i], q_v[i], r_v[i]);
        end
`ifdef DIV32_DBZ_FLAG_EN
        compared++;
        if (dbz_v[i] !== (y == 32'd0)) begin
            mismatched++;
            $display("FAIL %s bpc=%0d dbz during run: got %b expected %b", tag, 1 << i, dbz_v[i], y == 32'd0);
        end
`endif
        wait_done(i, cyc);
        compared++;
        if (cyc != (32 >> i)) begin
            mismatched++;
            $display("FAIL %s bpc=%0d latency: got %0d expected %0d", tag, 1 << i, cyc, 32 >> i);
        end
        compared++;
        if (q_v[i] !== eq || r_v[i] !== er) begin
            mismatched++;
            $display("FAIL %s bpc=%0d a=%h b=%h: q=%h r=%h, expected q=%h r=%h",
                     tag, 1 << i, x, y, q_v[i], r_v[i], eq, er);
        end
`ifdef DIV32_DBZ_FLAG_EN
        compared++;
        if (dbz_v[i] !== (y == 32'd0)) begin
            mismatched++;
            $display("FAIL %s bpc=%0d dbz after: got %b expected %b", tag, 1 << i, dbz_v[i], y == 32'd0);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (busy_v[i] !== 1'b0 || q_v[i] !== 32'd0 || r_v[i] !== 32'd0) begin
                    mismatched++;
                    $display("FAIL reset bpc=%0d: busy=%b q=%h r=%h, expected 0 0 0",
                             1 << i, busy_v[i], q_v[i], r_v[i]);
                end
`ifdef DIV32_DBZ_FLAG_EN
                compared++;
                if (dbz_v[i] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL reset_dbz bpc=%0d: got %b expected 0", 1 << i, dbz_v[i]);
                end
`endif
            end
        end
    endtask

    task automatic test_basic(input int i);
        run_op(i, 32'd207363151, 32'd12345, 32'd16797, 32'd4186, "basic");
    endtask

    task automatic test_corners(input int i);
        run_op(i, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "b_one");
        run_op(i, 32'd5, 32'd7, 32'd0, 32'd5, "a_lt_b");
        run_op(i, 32'd0, 32'd9, 32'd0, 32'd0, "a_zero");
    endtask

    task automatic test_dbz(input int i);
        run_op(i, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, "dbz");
        run_op(i, 32'd8, 32'd2, 32'd4, 32'd0, "dbz_clear");
    endtask

    task automatic test_back_to_back(input int i);
        int cyc;
        @(negedge clk);
        a = 32'd77;
        b = 32'd5;
        start[i] = 1'b1;
        @(negedge clk);
        a = 32'h0000_DEAD;
        b = 32'd3;
        wait_done(i, cyc);
        compared++;
        if (cyc != (32 >> i) || q_v[i] !== 32'd15 || r_v[i] !== 32'd2) begin
            mismatched++;
            $display("FAIL b2b_first bpc=%0d: lat=%0d q=%h r=%h, expected lat=%0d q=f r=2",
                     1 << i, cyc, q_v[i], r_v[i], 32 >> i);
        end
        a = 32'd1000;
        b = 32'd10;
        @(negedge clk);
        start[i] = 1'b0;
        compared++;
        if (busy_v[i] !== 1'b1 || q_v[i] !== 32'd0) begin
            mismatched++;
            $display("FAIL b2b_accept bpc=%0d: busy=%b q=%h, expected busy=1 q=0", 1 << i, busy_v[i], q_v[i]);
        end
        wait_done(i, cyc);
        compared++;
        if (cyc != (32 >> i) || q_v[i] !== 32'd100 || r_v[i] !== 32'd0) begin
            mismatched++;
            $display("FAIL b2b_second bpc=%0d: lat=%0d q=%h r=%h, expected lat=%0d q=64 r=0",
                     1 << i, cyc, q_v[i], r_v[i], 32 >> i);
        end
    endtask

    task automatic test_ignore(input int i);
        int cyc;
        logic [31:0] x, y;
        x = $urandom;
        y = $urandom_range(1, 100000);
        launch(i, x, y);
        cyc = 0;
        while (busy_v[i] && cyc < 200) begin
            start[i] = (cyc % 3 == 1);
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            cyc++;
        end
        start[i] = 1'b0;
        compared++;
        if (cyc != (32 >> i) || q_v[i] !== ref_q(x, y) || r_v[i] !== ref_r(x, y)) begin
            mismatched++;
            $display("FAIL ignore bpc=%0d: lat=%0d q=%h r=%h, expected lat=%0d q=%h r=%h",
                     1 << i, cyc, q_v[i], r_v[i], 32 >> i, ref_q(x, y), ref_r(x, y));
        end
        repeat (3) @(negedge clk);
        compared++;
        if (busy_v[i] !== 1'b0 || q_v[i] !== ref_q(x, y) || r_v[i] !== ref_r(x, y)) begin
            mismatched++;
            $display("FAIL hold bpc=%0d: busy=%b q=%h r=%h, expected busy=0 q=%h r=%h",
                     1 << i, busy_v[i], q_v[i], r_v[i], ref_q(x, y), ref_r(x, y));
        end
    endtask

    task automatic test_reset_mid(input int i);
        launch(i, $urandom, $urandom_range(1, 1000));
        repeat ((16 >> i) - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (busy_v[i] !== 1'b0 || q_v[i] !== 32'd0 || r_v[i] !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mid bpc=%0d: busy=%b q=%h r=%h, expected 0 0 0",
                     1 << i, busy_v[i], q_v[i], r_v[i]);
        end
        run_op(i, 32'd50, 32'd7, 32'd7, 32'd1, "after_reset");
    endtask

    task automatic test_random(input int i);
        logic [31:0] x, y;
        for (int k = 0; k < 8; k++) begin
            x = $urandom;
            y = (k % 4 == 0) ? 32'($urandom_range(1, 15)) : ($urandom >> $urandom_range(0, 31));
            if (k == 5) y = x + 32'd1;
            run_op(i, x, y, ref_q(x, y), ref_r(x, y), "random");
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 3; i++) begin
            test_basic(i);
            test_corners(i);
            test_dbz(i);
            test_back_to_back(i);
            test_ignore(i);
            test_reset_mid(i);
            test_random(i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
